fp_mult_seq: RTL and testbench
==============================

Name: fp_mult_seq

Overview:
- Parametrised, handshaked IEEE-754 floating-point multiplier. Successor to the fixed single-precision multiply wrapper.
- Exponent and fraction widths are generic. Default is binary32.
- Mantissa product uses a radix-2 shift-add datapath, one bit per cycle, then a round-to-nearest-even stage.
- Valid/ready on input and output lets it sit between operand queues and result consumers with backpressure. Special operands bypass the datapath.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, fraction field width (hidden bit excluded).
- W = 1+EXP_W+MAN_W (local, derived), word width.
- BIAS = 2^(EXP_W-1)-1 (local, derived).

Ports:
- clk  in  1  single clock, rising edge.
- res  in  1  synchronous active-high reset.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- flt_a  in  W  operand A.
- flt_b  in  W  operand B.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts result.
- flt_out  out  W  product.
- flags  out  4  [3] invalid, [2] overflow, [1] underflow, [0] inexact; valid with out_valid.

Behaviour:
- Reset (res high at a clk edge):
  - state=IDLE; out_valid=0; flt_out=0; flags=0; counters and accumulators cleared.
  - in_ready=0 while res is high. Any operation in flight is abandoned, with no output.
- in_ready = (state==IDLE) && !res. Accept occurs on the edge where in_valid && in_ready; flt_a and flt_b are registered on that edge.
- FSM states:
  - IDLE -> MUL on accept with finite nonzero operands.
  - IDLE -> DONE on accept with special operands; the result is registered on the accepting edge.
  - MUL: MAN_W+1 cycles, one multiplier bit per cycle (shift-add into a 2*(MAN_W+1)-bit accumulator). Then -> RND.
  - RND: 1 cycle: normalise, round, check range, register flt_out and flags. Then -> DONE.
  - DONE: out_valid=1. flt_out and flags are held stable until out_valid && out_ready, then -> IDLE.
- Latency and throughput:
  - Normal path: out_valid high after accept edge + MAN_W+2 edges (25 for defaults).
  - Special path: out_valid high the cycle after the accept edge.
  - in_ready rises the cycle after the output handshake. There is no same-cycle bypass, so throughput is one operation per MAN_W+4 cycles best case.
- Arithmetic:
  - sign = sa ^ sb.
  - Subnormal inputs are treated as signed zero (denormals-are-zero).
  - Exponent is computed as ea+eb-BIAS in EXP_W+2 bits, signed.
  - If the product MSB is set: shift right 1, exponent +1.
  - Rounding is round-to-nearest-even using guard bit plus sticky (OR of all lower bits).
  - A rounding carry-out renormalises: fraction=0, exponent +1.
  - inexact = guard|sticky.
  - Final exponent >= 2^EXP_W-1: result is ±Inf; overflow=1, inexact=1.
  - Final exponent <= 0: result is signed zero (flush-to-zero, no subnormal output); underflow=1, inexact=1.
- Special operands:
  - Any NaN input gives canonical qNaN (sign 0, exponent all ones, fraction MSB only). invalid=1 only if an input is a signalling NaN (fraction MSB 0).
  - Inf × zero gives qNaN with invalid=1.
  - Inf × finite nonzero, or Inf × Inf, gives signed Inf with no flags.
  - Zero × finite gives signed zero with no flags.
- in_valid while busy: ignored. Operands must be held by the source until accepted.
- out_ready asserted while out_valid=0: no effect.

Test Plan:
- 0x43918000 × 0x428CA000 (291.0×70.3125) -> flt_out=0x469FD9E0, flags=0. out_valid rises exactly 25 cycles after accept.
- 0x43918000 × 0xC3910000 (291.0×-290.0) -> 0xC7A4D300, flags=0. Rounding check: 0x3F800001 × 0x3F800001 -> 0x3F800002, flags=0001.
- 0x7F000000 × 0x7F000000 -> 0x7F800000, flags=0101. 0x00800000 × 0x00800000 -> 0x00000000, flags=0011.
- 0x7F800000 × 0x00000000 -> 0x7FC00000, flags=1000. 0x7F800001 × 0x3F800000 -> 0x7FC00000, flags=1000. Both take 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 and new operands -> in_ready stays 0, flt_out and flags stable. Raise out_ready for 1 cycle -> out_valid=0 next cycle and in_ready=1.
- Assert res for 1 cycle at MUL cycle 10 -> next cycle out_valid=0, flt_out=0, in_ready=1. A subsequent 0x3F800000 × 0x40000000 returns 0x40000000 with no residue from the aborted operation.

Source files
------------

// File: rtl/fp_mult_seq_if.sv
// Operand/result handshake bundle for fp_mult_seq: valid/ready on the operand side
// and on the result side, with the product word and its exception flags.
interface fp_mult_seq_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] flt_a;
    logic [W-1:0] flt_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] flt_out;
    logic [3:0]   flags;

    modport master (
        output in_valid, flt_a, flt_b, out_ready,
        input  in_ready, out_valid, flt_out, flags
    );

    modport slave (
        input  in_valid, flt_a, flt_b, out_ready,
        output in_ready, out_valid, flt_out, flags
    );
endinterface

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 multiplier: radix-2 shift-add significand product, RNE rounding,
// denormals-are-zero inputs, flush-to-zero outputs, special operands bypass the datapath.
module fp_mult_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic          clk,
    input logic          res,
    fp_mult_seq_if.slave bus
);
    localparam int unsigned W     = 1 + EXP_W + MAN_W;
    localparam int unsigned P     = MAN_W + 1;
    localparam int unsigned EW2   = EXP_W + 2;
    localparam int unsigned CNT_W = $clog2(P + 1);
    localparam int unsigned BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX  = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, RND, DONE} state_t;

    state_t             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2*P-1:0]     mcand_q,  mcand_d;
    logic [P-1:0]       mplier_q, mplier_d;
    logic [2*P-1:0]     acc_q,    acc_d;
    logic [EW2-1:0]     exp_q,    exp_d;
    logic               sign_q,   sign_d;
    logic [W-1:0]       out_q,    out_d;
    logic [3:0]         flags_q,  flags_d;

    logic               in_ready;
    logic               sa, sb;
    logic [EXP_W-1:0]   ea, eb;
    logic [MAN_W-1:0]   fa, fb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_snan, b_snan;
    logic               special;

    assign {sa, ea, fa} = bus.flt_a;
    assign {sb, eb, fb} = bus.flt_b;

    // Zero exponent covers subnormals too, so they fall into the signed-zero path.
    assign a_nan   = (&ea) && (|fa);
    assign b_nan   = (&eb) && (|fb);
    assign a_inf   = (&ea) && !(|fa);
    assign b_inf   = (&eb) && !(|fb);
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_snan  = a_nan && !fa[MAN_W-1];
    assign b_snan  = b_nan && !fb[MAN_W-1];
    assign special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

    assign in_ready      = (state_q == IDLE) && !res;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == DONE);
    assign bus.flt_out   = out_q;
    assign bus.flags     = flags_q;

    logic [2*P-2:0]     norm;
    logic [EW2-1:0]     exp_n, exp_r;
    logic [MAN_W-1:0]   frac, frac_r;
    logic [MAN_W:0]     frac_inc;
    logic               guard, sticky, rnd_up, ovf, unf;

    // The hidden bit sits at 2P-1 or 2P-2; after alignment it is dropped from norm.
    always_comb begin
        norm     = acc_q[2*P-1] ? acc_q[2*P-2:0] : {acc_q[2*P-3:0], 1'b0};
        exp_n    = acc_q[2*P-1] ? exp_q + EW2'(1) : exp_q;
        frac     = norm[2*P-2 -: MAN_W];
        guard    = norm[P-1];
        sticky   = |norm[P-2:0];
        rnd_up   = guard & (sticky | frac[0]);
        frac_inc = {1'b0, frac} + (MAN_W+1)'(rnd_up);
        frac_r   = frac_inc[MAN_W-1:0];
        exp_r    = exp_n + EW2'(frac_inc[MAN_W]);
        ovf      = !exp_r[EW2-1] && (exp_r >= EW2'(EMAX));
        unf      = exp_r[EW2-1] || (exp_r == '0);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        out_d    = out_q;
        flags_d  = flags_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    sign_d = sa ^ sb;
                    if (special) begin
                        state_d = DONE;
                        if (a_nan || b_nan) begin
                            out_d   = QNAN;
                            flags_d = {a_snan | b_snan, 3'b000};
                        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                            out_d   = QNAN;
                            flags_d = 4'b1000;
                        end else if (a_inf || b_inf) begin
                            out_d   = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                            flags_d = '0;
                        end else begin
                            out_d   = {sa ^ sb, {(W-1){1'b0}}};
                            flags_d = '0;
                        end
                    end else begin
                        state_d  = MUL;
                        cnt_d    = '0;
                        acc_d    = '0;
                        mcand_d  = {{P{1'b0}}, 1'b1, fa};
                        mplier_d = {1'b1, fb};
                        exp_d    = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
                    end
                end
            end
            MUL: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(P - 1)) begin
                    state_d = RND;
                end
            end
            RND: begin
                state_d = DONE;
                if (ovf) begin
                    out_d   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (unf) begin
                    out_d   = {sign_q, {(W-1){1'b0}}};
                    flags_d = 4'b0011;
                end else begin
                    out_d   = {sign_q, exp_r[EXP_W-1:0], frac_r};
                    flags_d = {3'b000, guard | sticky};
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            out_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
        end
    end
endmodule

// File: tb/tb_fp_mult_seq.sv
// Directed, table-driven bench for fp_mult_seq (binary32), plus backpressure and
// mid-operation reset sequences.
module tb_fp_mult_seq;
    logic clk;
    logic res;
    int   pass_cnt;
    int   total_cnt;

    fp_mult_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fp_mult_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] f, input int lat);
        vec_t v;
        v.a = a; v.b = b; v.r = r; v.f = f; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flt_a    = a;
        bus.flt_b    = b;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // lat = edges after the accepting edge until out_valid is seen
    task automatic wait_out(output logic [31:0] r, output logic [3:0] f, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) check("result_timeout", 32'd0, 32'd1);
        r = bus.flt_out;
        f = bus.flags;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        logic        stable;

        pass_cnt      = 0;
        total_cnt     = 0;
        res           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.flt_a     = '0;
        bus.flt_b     = '0;

        add(32'h43918000, 32'h428CA000, 32'h469FD9E0, 4'b0000, 25);
        add(32'h43918000, 32'hC3910000, 32'hC7A4D300, 4'b0000, 25);
        add(32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 25);
        add(32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 25);
        add(32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 25);
        add(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 0);
        add(32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 0);
        add(32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 25);
        add(32'h3FC00000, 32'h3F800001, 32'h3FC00002, 4'b0001, 25);
        add(32'h3FC00000, 32'h3F800003, 32'h3FC00004, 4'b0001, 25);
        add(32'h3FFFFFFF, 32'h3F800001, 32'h40000000, 4'b0001, 25);
        add(32'h7F800000, 32'hFF800000, 32'hFF800000, 4'b0000, 0);
        add(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 0);
        add(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 0);
        add(32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 0);
        add(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 0);

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_flt_out",   bus.flt_out,        32'd0);
        check("rst_flags",     32'(bus.flags),     32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        @(negedge clk);
        res = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].a, vecs[i].b);
            wait_out(r, f, lat);
            check($sformatf("v%0d_out", i),   r,           vecs[i].r);
            check($sformatf("v%0d_flags", i), 32'(f),      32'(vecs[i].f));
            check($sformatf("v%0d_lat", i),   32'(lat),    32'(vecs[i].lat));
            handshake();
            check($sformatf("v%0d_ovalid_drop", i), 32'(bus.out_valid), 32'd0);
        end

        // Backpressure: result held while a new operand pair waits
        issue(32'h43918000, 32'h428CA000);
        wait_out(r, f, lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flt_a    = 32'h3F800000;
        bus.flt_b    = 32'h40000000;
        stable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.in_ready || !bus.out_valid || bus.flt_out !== 32'h469FD9E0 ||
                bus.flags !== 4'b0000) stable = 1'b0;
        end
        check("bp_hold_stable", 32'(stable), 32'd1);
        check("bp_flt_out",     bus.flt_out, 32'h469FD9E0);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_out_valid_after", 32'(bus.out_valid), 32'd0);
        check("bp_in_ready_after",  32'(bus.in_ready),  32'd1);

        // Reset during MUL abandons the operation
        issue(32'h43918000, 32'h428CA000);
        repeat (10) @(posedge clk);
        #1;
        check("mul_busy_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_flt_out",   bus.flt_out,        32'd0);
        @(negedge clk);
        res = 1'b0;
        #1;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        stable = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stable = 1'b0;
        end
        check("abort_no_output", 32'(stable), 32'd1);
        issue(32'h3F800000, 32'h40000000);
        wait_out(r, f, lat);
        check("post_abort_out",   r,         32'h40000000);
        check("post_abort_flags", 32'(f),    32'd0);
        check("post_abort_lat",   32'(lat),  32'd25);
        handshake();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
